// File: rtl/frame_readout_ctrl.sv
// Streams one raw 24-bit BMP frame (no header) from a byte-wide frame-buffer RAM to the image
// writer in BMP row order, hiding the 1-cycle RAM read latency behind a 2-entry skid buffer.
module frame_readout_ctrl #(
    parameter int IMG_WIDTH  = 100,
    parameter int IMG_HEIGHT = 100,
    parameter int BPP        = 3,
    parameter int ADDR_W     = 15,
    parameter bit BOTTOM_UP  = 1'b1,
    parameter int LINE_GAP   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              line_last,
    output logic              frame_last
);
    localparam int ROW_BYTES = IMG_WIDTH * BPP;
    localparam int COL_W     = $clog2(ROW_BYTES + 1);
    localparam int ROW_W     = $clog2(IMG_HEIGHT + 1);
    localparam int GAP_W     = $clog2(LINE_GAP + 2);

    localparam logic [ROW_W-1:0]  FIRST_ROW  = BOTTOM_UP ? ROW_W'(IMG_HEIGHT - 1) : {ROW_W{1'b0}};
    localparam logic [ROW_W-1:0]  LAST_ROW   = BOTTOM_UP ? {ROW_W{1'b0}} : ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BOTTOM_UP ? (IMG_HEIGHT - 1) * ROW_BYTES : 0);
    // Going bottom-up, the row after the one just finished starts 2*ROW_BYTES-1 below its last byte.
    localparam logic [ADDR_W-1:0] ROW_BACK   = ADDR_W'(2 * ROW_BYTES - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(ROW_BYTES - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP   = GAP_W'(LINE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_GAP   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rvalid_q, rvalid_d;
    logic              rline_q, rline_d;
    logic              rframe_q, rframe_d;
    logic [9:0]        buf_q [2];
    logic [9:0]        buf_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;

    logic pop_s;
    logic credit_ok_s;
    logic rd_issue_s;
    logic row_end_s;
    logic last_row_s;

    // Read credit: occupancy plus the read now returning, less this cycle's pop, must stay below 2.
    always_comb begin
        pop_s       = (occ_q != 2'd0) && pix_ready;
        credit_ok_s = ({1'b0, occ_q} + {2'b00, rvalid_q}) < (3'd2 + {2'b00, pop_s});
        rd_issue_s  = (state_q == S_READ) && credit_ok_s;
        row_end_s   = (col_q == LAST_COL);
        last_row_s  = (row_q == LAST_ROW);
    end

    // Skid buffer bookkeeping, read sequencing and frame FSM next-state.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        gap_d    = gap_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rvalid_d = rd_issue_s;
        rline_d  = row_end_s;
        rframe_d = row_end_s && last_row_s;
        buf_d    = buf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (rvalid_q) begin
            buf_d[wr_ptr_q] = {rframe_q, rline_q, mem_rdata};
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, rvalid_q} - {1'b0, pop_s};

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_READ;
                    col_d   = {COL_W{1'b0}};
                    row_d   = FIRST_ROW;
                    addr_d  = FIRST_ADDR;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_issue_s && row_end_s) begin
                    col_d = {COL_W{1'b0}};
                    if (last_row_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        row_d  = BOTTOM_UP ? row_q - ROW_W'(1) : row_q + ROW_W'(1);
                        addr_d = BOTTOM_UP ? addr_q - ROW_BACK : addr_q + ADDR_W'(1);
                        gap_d  = {GAP_W{1'b0}};
                        state_d = (LINE_GAP > 0) ? S_GAP : S_READ;
                    end
                end else if (rd_issue_s) begin
                    col_d  = col_q + COL_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    state_d = S_READ;
                end
            end
            S_GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = S_READ;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DRAIN: begin
                if ((occ_d == 2'd0) && !rvalid_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort drops everything, including the byte still on its way back from RAM.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            rvalid_d = 1'b0;
            occ_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            busy_d = busy_d;
        end
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            col_q    <= {COL_W{1'b0}};
            row_q    <= {ROW_W{1'b0}};
            addr_q   <= {ADDR_W{1'b0}};
            gap_q    <= {GAP_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rline_q  <= 1'b0;
            rframe_q <= 1'b0;
            buf_q[0] <= 10'd0;
            buf_q[1] <= 10'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            rline_q  <= rline_d;
            rframe_q <= rframe_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_rd_en  = rd_issue_s;
    assign mem_addr   = addr_q;
    assign pix_valid  = (occ_q != 2'd0);
    assign pix_data   = buf_q[rd_ptr_q][7:0];
    assign line_last  = buf_q[rd_ptr_q][8];
    assign frame_last = buf_q[rd_ptr_q][9];

endmodule

// File: tb/tb_frame_readout_ctrl.sv
// Directed bench for frame_readout_ctrl: full default frame, small stalled/gapped frames,
// abort, re-start while busy and mid-frame reset.
module tb_frame_readout_ctrl;
    localparam int FB = 30000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic        d_start, d_abort, d_busy, d_done, d_mem_rd_en, d_pix_valid, d_pix_ready;
    logic        d_line_last, d_frame_last;
    logic [14:0] d_mem_addr;
    logic [7:0]  d_mem_rdata, d_pix_data;
    // Small 4x2 instances, without and with line gap.
    logic        s_start, s_abort, s_busy, s_done, s_mem_rd_en, s_pix_valid, s_pix_ready;
    logic        s_line_last, s_frame_last;
    logic [4:0]  s_mem_addr;
    logic [7:0]  s_mem_rdata, s_pix_data;
    logic        g_start, g_abort, g_busy, g_done, g_mem_rd_en, g_pix_valid, g_pix_ready;
    logic        g_line_last, g_frame_last;
    logic [4:0]  g_mem_addr;
    logic [7:0]  g_mem_rdata, g_pix_data;

    frame_readout_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort), .busy(d_busy), .done(d_done),
        .mem_rd_en(d_mem_rd_en), .mem_addr(d_mem_addr), .mem_rdata(d_mem_rdata),
        .pix_data(d_pix_data), .pix_valid(d_pix_valid), .pix_ready(d_pix_ready),
        .line_last(d_line_last), .frame_last(d_frame_last));

    frame_readout_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BPP(3), .ADDR_W(5), .BOTTOM_UP(1'b1), .LINE_GAP(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .busy(s_busy), .done(s_done),
        .mem_rd_en(s_mem_rd_en), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
        .pix_data(s_pix_data), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .line_last(s_line_last), .frame_last(s_frame_last));

    frame_readout_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BPP(3), .ADDR_W(5), .BOTTOM_UP(1'b1), .LINE_GAP(3)) dut_g (
        .clk(clk), .rst_n(rst_n), .start(g_start), .abort(g_abort), .busy(g_busy), .done(g_done),
        .mem_rd_en(g_mem_rd_en), .mem_addr(g_mem_addr), .mem_rdata(g_mem_rdata),
        .pix_data(g_pix_data), .pix_valid(g_pix_valid), .pix_ready(g_pix_ready),
        .line_last(g_line_last), .frame_last(g_frame_last));

    function automatic logic [7:0] ram_val(input int a);
        return 8'(a ^ (a >> 7));
    endfunction

    // k-th byte of a default frame: rows 99 down to 0, 300 bytes each.
    function automatic int addr_of(input int k);
        return (99 - k / 300) * 300 + k % 300;
    endfunction

    always @(posedge clk) begin
        if (d_mem_rd_en) d_mem_rdata <= ram_val(int'(d_mem_addr));
        if (s_mem_rd_en) s_mem_rdata <= {3'b000, s_mem_addr};
        if (g_mem_rd_en) g_mem_rdata <= {3'b000, g_mem_addr};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_default(input string tag);
        chk({tag, "_busy"}, int'(d_busy), 0);
        chk({tag, "_done"}, int'(d_done), 0);
        chk({tag, "_rd_en"}, int'(d_mem_rd_en), 0);
        chk({tag, "_addr"}, int'(d_mem_addr), 0);
        chk({tag, "_pix_data"}, int'(d_pix_data), 0);
        chk({tag, "_pix_valid"}, int'(d_pix_valid), 0);
        chk({tag, "_line_last"}, int'(d_line_last), 0);
        chk({tag, "_frame_last"}, int'(d_frame_last), 0);
    endtask

    // Full default frame with pix_ready=1, cycle-exact; optional extra start at cycle 100.
    task automatic run_full_frame(input bit extra_start);
        int hs;
        int dn;
        hs = 0;
        dn = 0;
        @(posedge clk); #1 d_start = 1'b1; d_pix_ready = 1'b1;
        for (int c = 1; c <= FB + 5; c++) begin
            @(posedge clk); #1 d_start = extra_start && (c == 100);
            @(negedge clk);
            chk("rd_en", int'(d_mem_rd_en), int'(c <= FB));
            if (d_mem_rd_en && c <= FB) chk("addr", int'(d_mem_addr), addr_of(c - 1));
            if (c == 1) chk("first_addr", int'(d_mem_addr), 29700);
            if (c == FB) chk("last_addr", int'(d_mem_addr), 299);
            chk("busy", int'(d_busy), int'(c <= FB + 2));
            chk("pix_valid", int'(d_pix_valid), int'(c >= 3 && c <= FB + 2));
            chk("done", int'(d_done), int'(c == FB + 3));
            if (d_done) dn++;
            if (d_pix_valid && d_pix_ready) begin
                chk("pix_data", int'(d_pix_data), int'(ram_val(addr_of(hs))));
                chk("line_last", int'(d_line_last), int'(hs % 300 == 299));
                chk("frame_last", int'(d_frame_last), int'(hs == FB - 1));
                hs++;
            end
        end
        chk("frame_handshakes", hs, FB);
        chk("done_count", dn, 1);
    endtask

    typedef struct {
        int         stall;
        logic [7:0] data;
        logic       line;
        logic       frame;
    } vec_t;

    vec_t tbl [24];

    initial begin
        int   hs;
        int   got;
        bit   held_v;
        logic [7:0] held_d;

        tbl[0]  = '{0, 8'd12, 1'b0, 1'b0}; tbl[1]  = '{2, 8'd13, 1'b0, 1'b0};
        tbl[2]  = '{1, 8'd14, 1'b0, 1'b0}; tbl[3]  = '{0, 8'd15, 1'b0, 1'b0};
        tbl[4]  = '{3, 8'd16, 1'b0, 1'b0}; tbl[5]  = '{0, 8'd17, 1'b0, 1'b0};
        tbl[6]  = '{1, 8'd18, 1'b0, 1'b0}; tbl[7]  = '{1, 8'd19, 1'b0, 1'b0};
        tbl[8]  = '{0, 8'd20, 1'b0, 1'b0}; tbl[9]  = '{2, 8'd21, 1'b0, 1'b0};
        tbl[10] = '{0, 8'd22, 1'b0, 1'b0}; tbl[11] = '{1, 8'd23, 1'b1, 1'b0};
        tbl[12] = '{2, 8'd0,  1'b0, 1'b0}; tbl[13] = '{0, 8'd1,  1'b0, 1'b0};
        tbl[14] = '{0, 8'd2,  1'b0, 1'b0}; tbl[15] = '{2, 8'd3,  1'b0, 1'b0};
        tbl[16] = '{1, 8'd4,  1'b0, 1'b0}; tbl[17] = '{0, 8'd5,  1'b0, 1'b0};
        tbl[18] = '{3, 8'd6,  1'b0, 1'b0}; tbl[19] = '{0, 8'd7,  1'b0, 1'b0};
        tbl[20] = '{0, 8'd8,  1'b0, 1'b0}; tbl[21] = '{1, 8'd9,  1'b0, 1'b0};
        tbl[22] = '{0, 8'd10, 1'b0, 1'b0}; tbl[23] = '{2, 8'd11, 1'b1, 1'b1};

        rst_n = 1'b0;
        d_start = 1'b0; d_abort = 1'b0; d_pix_ready = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_pix_ready = 1'b0;
        g_start = 1'b0; g_abort = 1'b0; g_pix_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero_default("reset");
        chk("reset_s_valid", int'(s_pix_valid), 0);
        chk("reset_g_busy", int'(g_busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Small frame, table-driven stalls: byte order, markers, stability under stall.
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            held_v = 1'b0;
            held_d = 8'd0;
            for (int s = 0; s < tbl[i].stall; s++) begin
                @(posedge clk); #1 s_pix_ready = 1'b0;
                @(negedge clk);
                if (held_v) begin
                    chk("s_stall_valid", int'(s_pix_valid), 1);
                    chk("s_stall_data", int'(s_pix_data), int'(held_d));
                end
                held_v = s_pix_valid;
                held_d = s_pix_data;
            end
            got = 0;
            for (int w = 0; w < 20 && got == 0; w++) begin
                @(posedge clk); #1 s_pix_ready = 1'b1;
                @(negedge clk);
                if (w == 0 && held_v) chk("s_release_data", int'(s_pix_data), int'(held_d));
                if (s_pix_valid) got = 1;
            end
            chk("s_byte_seen", got, 1);
            if (got == 1) begin
                chk("s_pix_data", int'(s_pix_data), int'(tbl[i].data));
                chk("s_line_last", int'(s_line_last), int'(tbl[i].line));
                chk("s_frame_last", int'(s_frame_last), int'(tbl[i].frame));
            end
        end
        @(posedge clk); #1 s_pix_ready = 1'b0;
        @(negedge clk);
        chk("s_done", int'(s_done), 1);
        chk("s_busy_low", int'(s_busy), 0);
        chk("s_empty", int'(s_pix_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s_done_once", int'(s_done), 0);

        // Small frame with a 3-cycle line gap: exact read pattern and identical stream.
        hs = 0;
        @(posedge clk); #1 g_start = 1'b1; g_pix_ready = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1 g_start = 1'b0;
            @(negedge clk);
            chk("g_rd_en", int'(g_mem_rd_en), int'((c >= 1 && c <= 12) || (c >= 16 && c <= 27)));
            if (g_mem_rd_en && c <= 12) chk("g_addr", int'(g_mem_addr), 11 + c);
            if (g_mem_rd_en && c >= 16) chk("g_addr", int'(g_mem_addr), c - 16);
            chk("g_done", int'(g_done), int'(c == 30));
            if (g_pix_valid && hs < 24) begin
                chk("g_pix_data", int'(g_pix_data), int'(tbl[hs].data));
                chk("g_line_last", int'(g_line_last), int'(tbl[hs].line));
                chk("g_frame_last", int'(g_frame_last), int'(tbl[hs].frame));
                hs++;
            end else if (g_pix_valid) begin
                hs++;
            end
        end
        chk("g_handshakes", hs, 24);

        // Full default frame, with a start pulse at cycle 100 that must be ignored.
        run_full_frame(1'b1);

        // Abort after 500 handshakes.
        hs = 0;
        @(posedge clk); #1 d_start = 1'b1; d_pix_ready = 1'b1;
        @(posedge clk); #1 d_start = 1'b0;
        for (int c = 0; c < 1000 && hs < 500; c++) begin
            @(negedge clk);
            if (d_pix_valid && d_pix_ready) hs++;
            if (hs < 500) begin
                @(posedge clk); #1;
            end
        end
        chk("abort_hs_reached", hs, 500);
        @(posedge clk); #1 d_abort = 1'b1;
        @(posedge clk); #1 d_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(d_busy), 0);
        chk("abort_valid", int'(d_pix_valid), 0);
        chk("abort_rd_en", int'(d_mem_rd_en), 0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_no_done", int'(d_done), 0);
            chk("abort_stays_empty", int'(d_pix_valid), 0);
        end

        // Restart after abort, then reset at cycle 1000 of that frame.
        @(posedge clk); #1 d_start = 1'b1;
        for (int c = 1; c < 1000; c++) begin
            @(posedge clk); #1 d_start = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                chk("restart_rd_en", int'(d_mem_rd_en), 1);
                chk("restart_addr", int'(d_mem_addr), 29700);
            end
            if (c == 3) begin
                chk("restart_valid", int'(d_pix_valid), 1);
                chk("restart_data", int'(d_pix_data), int'(ram_val(29700)));
            end
            if (c == 999) chk("restart_busy", int'(d_busy), 1);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk_zero_default("midrst_a");
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero_default("midrst_b");
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_done", int'(d_done), 0);
            chk("post_rst_busy", int'(d_busy), 0);
            @(posedge clk); #1;
        end

        run_full_frame(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
